// File: rtl/prio_enc_pkg.sv
// Shared types for the priority encoder block.
package prio_enc_pkg;

  typedef enum logic {
    PRIO_FIXED = 1'b0,
    PRIO_RR    = 1'b1
  } prio_mode_e;

endpackage

// File: rtl/prio_find_first.sv
// Combinational wrap-around search: scans downward from start, wrapping
// from bit 0 to bit N-1, and reports the first set bit found.
module prio_find_first #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    int pos;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int i = 0; i < N; i++) begin
      pos = int'(start) - i;
      if (pos < 0) pos = pos + N;
      if (!found && vec[pos]) begin
        found = 1'b1;
        idx   = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered priority encoder with valid/ready handshake on both sides.
// Fixed mode grants the highest set bit; RR mode rotates the search start.
module prio_encoder_rr
  import prio_enc_pkg::*;
#(
  parameter int         N     = 8,
  parameter prio_mode_e MODE  = PRIO_FIXED,
  parameter int         IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     out_onehot,
  output logic             out_none,
  output logic             out_multi
);

  logic             out_valid_reg;
  logic [IDX_W-1:0] out_idx_reg;
  logic [N-1:0]     out_onehot_reg;
  logic             out_none_reg;
  logic             out_multi_reg;
  logic [IDX_W-1:0] ptr_reg;

  logic             accept;
  logic             transfer;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_found;
  logic [N-1:0]     onehot_next;
  logic             multi_next;

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;
  assign transfer = out_valid_reg && out_ready;

  prio_find_first #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_find (
    .vec   (in_req),
    .start (ptr_reg),
    .idx   (grant_idx),
    .found (grant_found)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_onehot
      assign onehot_next[gi] = grant_found && (grant_idx == IDX_W'(gi));
    end
  endgenerate

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_next = |(in_req & (in_req - N'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      out_idx_reg    <= '0;
      out_onehot_reg <= '0;
      out_none_reg   <= 1'b0;
      out_multi_reg  <= 1'b0;
      ptr_reg        <= IDX_W'(N - 1);
    end else if (accept) begin
      out_valid_reg  <= 1'b1;
      out_idx_reg    <= grant_idx;
      out_onehot_reg <= onehot_next;
      out_none_reg   <= !grant_found;
      out_multi_reg  <= multi_next;
      // The granted bit becomes lowest priority for the next search.
      if (MODE == PRIO_RR && grant_found) begin
        if (grant_idx == '0) ptr_reg <= IDX_W'(N - 1);
        else                 ptr_reg <= grant_idx - IDX_W'(1);
      end
    end else if (transfer) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_idx    = out_idx_reg;
  assign out_onehot = out_onehot_reg;
  assign out_none   = out_none_reg;
  assign out_multi  = out_multi_reg;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench driving a fixed-priority and a round-robin instance
// with identical stimulus and comparing both against a reference model.
module tb_prio_encoder_rr;
  import prio_enc_pkg::*;

  localparam int N     = 8;
  localparam int IDX_W = $clog2(N);

  typedef struct {
    int         idx;
    logic [N-1:0] oh;
    bit         none;
    bit         multi;
  } res_t;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic [N-1:0] in_req;
  logic out_ready;

  logic             f_in_ready, f_out_valid, f_out_none, f_out_multi;
  logic [IDX_W-1:0] f_out_idx;
  logic [N-1:0]     f_out_onehot;
  logic             r_in_ready, r_out_valid, r_out_none, r_out_multi;
  logic [IDX_W-1:0] r_out_idx;
  logic [N-1:0]     r_out_onehot;

  int checks   = 0;
  int failures = 0;

  res_t fq[$];
  res_t rq[$];
  int   rr_log[$];
  bit   capture = 0;
  bit   m_valid = 0;
  bit   m_clean = 1;
  int   m_ptr   = N - 1;

  prio_encoder_rr #(.N(N), .MODE(PRIO_FIXED)) dut_fixed (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (f_in_ready),
    .in_req     (in_req),
    .out_valid  (f_out_valid),
    .out_ready  (out_ready),
    .out_idx    (f_out_idx),
    .out_onehot (f_out_onehot),
    .out_none   (f_out_none),
    .out_multi  (f_out_multi)
  );

  prio_encoder_rr #(.N(N), .MODE(PRIO_RR)) dut_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (r_in_ready),
    .in_req     (in_req),
    .out_valid  (r_out_valid),
    .out_ready  (out_ready),
    .out_idx    (r_out_idx),
    .out_onehot (r_out_onehot),
    .out_none   (r_out_none),
    .out_multi  (r_out_multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: descend from ptr with wrap-around, first set bit wins.
  function automatic res_t model(input logic [N-1:0] req, input int ptr);
    res_t r;
    r.idx   = 0;
    r.oh    = '0;
    r.none  = (req == '0);
    r.multi = ($countones(req) > 1);
    for (int i = 0; i < N; i++) begin
      int c;
      c = (ptr - i + N) % N;
      if (req[c]) begin
        r.idx = c;
        r.oh  = '0;
        r.oh[c] = 1'b1;
        break;
      end
    end
    return r;
  endfunction

  task automatic cmp_out(input string who, input logic [IDX_W-1:0] idx, input logic [N-1:0] oh,
                         input logic none, input logic multi, input res_t e);
    chk({who, "_idx"},    64'(idx),   64'(e.idx));
    chk({who, "_onehot"}, 64'(oh),    64'(e.oh));
    chk({who, "_none"},   64'(none),  64'(e.none));
    chk({who, "_multi"},  64'(multi), 64'(e.multi));
  endtask

  // Monitor on the falling edge: inputs are stable and outputs settled.
  always @(negedge clk) begin
    bit acc, xfer;
    res_t e;
    chk("f_in_ready", 64'(f_in_ready), 64'(!m_valid || out_ready));
    chk("r_in_ready", 64'(r_in_ready), 64'(!m_valid || out_ready));
    chk("f_out_valid", 64'(f_out_valid), 64'(m_valid));
    chk("r_out_valid", 64'(r_out_valid), 64'(m_valid));
    if (m_valid && fq.size() > 0 && rq.size() > 0) begin
      cmp_out("f", f_out_idx, f_out_onehot, f_out_none, f_out_multi, fq[0]);
      cmp_out("r", r_out_idx, r_out_onehot, r_out_none, r_out_multi, rq[0]);
    end else if (!m_valid && m_clean) begin
      e = '{idx: 0, oh: '0, none: 1'b0, multi: 1'b0};
      cmp_out("f_rst", f_out_idx, f_out_onehot, f_out_none, f_out_multi, e);
      cmp_out("r_rst", r_out_idx, r_out_onehot, r_out_none, r_out_multi, e);
    end

    if (rst_n !== 1'b1) begin
      fq.delete();
      rq.delete();
      m_valid = 0;
      m_clean = 1;
      m_ptr   = N - 1;
    end else begin
      xfer = m_valid && out_ready;
      acc  = in_valid && (!m_valid || out_ready);
      if (xfer) begin
        if (fq.size() > 0) void'(fq.pop_front());
        if (rq.size() > 0) begin
          e = rq.pop_front();
          if (capture) rr_log.push_back(e.idx);
        end
      end
      if (acc) begin
        fq.push_back(model(in_req, N - 1));
        e = model(in_req, m_ptr);
        rq.push_back(e);
        if (!e.none) m_ptr = (e.idx + N - 1) % N;
        m_clean = 0;
      end
      m_valid = acc ? 1'b1 : (xfer ? 1'b0 : m_valid);
    end
  end

  task automatic drive(input bit v, input logic [N-1:0] req, input bit rdy, input bit rst);
    in_valid  = v;
    in_req    = req;
    out_ready = rdy;
    rst_n     = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_rr[6];
    exp_rr = '{7, 6, 5, 4, 0, 7};
    drive(0, 8'h00, 0, 0);
    drive(0, 8'h00, 0, 0);
    // Release reset, then the 0x81 case and an all-zero vector.
    drive(0, 8'h00, 1, 1);
    drive(1, 8'h81, 1, 1);
    drive(1, 8'h00, 1, 1);
    drive(0, 8'h00, 1, 1);
    // Backpressure for three cycles with a vector waiting.
    drive(1, 8'h81, 1, 1);
    for (int i = 0; i < 3; i++) drive(1, 8'h01, 0, 1);
    drive(1, 8'h01, 1, 1);
    drive(0, 8'h00, 1, 1);
    // Round-robin rotation sequence.
    drive(0, 8'h00, 0, 0);
    drive(0, 8'h00, 1, 1);
    capture = 1;
    for (int i = 0; i < 4; i++) drive(1, 8'hFF, 1, 1);
    drive(1, 8'h81, 1, 1);
    drive(1, 8'h81, 1, 1);
    drive(0, 8'h00, 1, 1);
    capture = 0;
    chk("rr_seq_len", 64'(rr_log.size()), 64'(6));
    for (int i = 0; i < 6 && i < rr_log.size(); i++)
      chk($sformatf("rr_seq_%0d", i), 64'(rr_log[i]), 64'(exp_rr[i]));
    // Back-to-back stream.
    drive(1, 8'h10, 1, 1);
    drive(1, 8'h20, 1, 1);
    drive(1, 8'h40, 1, 1);
    drive(0, 8'h00, 1, 1);
    // Reset mid-operation with a pending result and ptr moved to 3.
    drive(0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 8'hFF, 1, 1);
    drive(0, 8'h00, 0, 1);
    drive(0, 8'h00, 0, 1);
    drive(1, 8'hFF, 1, 0);
    drive(1, 8'hFF, 1, 1);
    drive(0, 8'h00, 1, 1);
    // Random traffic, including occasional zero vectors and resets.
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r;
      r = N'($urandom);
      if ($urandom_range(0, 7) == 0) r = '0;
      drive($urandom_range(0, 3) != 0, r, $urandom_range(0, 2) != 0,
            $urandom_range(0, 99) != 0);
    end
    drive(0, 8'h00, 1, 1);
    drive(0, 8'h00, 1, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prio_encoder_rr.md
PRIO_ENCODER_RR -- requirements
Module: prio_encoder_rr

Interface
REQ-001 Parameter N, default 8: request vector width, legal range 2..64.
REQ-002 Parameter MODE, default PRIO_FIXED: PRIO_FIXED selects fixed priority, PRIO_RR selects round-robin.
REQ-003 Parameter IDX_W, default $clog2(N): index width, derived, never overridden.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 Port in_valid, input, 1: in_req is valid this cycle.
REQ-007 Port in_ready, output, 1: block accepts in_req this cycle.
REQ-008 Port in_req, input, N: request vector, any bit pattern legal.
REQ-009 Port out_valid, output, 1: result registers hold an unconsumed result.
REQ-010 Port out_ready, input, 1: consumer takes the result this cycle.
REQ-011 Port out_idx, output, IDX_W: bit number of the granted request.
REQ-012 Port out_onehot, output, N: one-hot of out_idx; all-zero when out_none=1.
REQ-013 Port out_none, output, 1: accepted vector was all-zero.
REQ-014 Port out_multi, output, 1: accepted vector had two or more bits set.

Function
REQ-015 Accept occurs when in_valid=1 and in_ready=1; transfer occurs when out_valid=1 and out_ready=1.
REQ-016 in_ready SHALL equal (!out_valid || out_ready), combinationally, with no dependency on in_valid.
REQ-017 An accepted vector's result SHALL appear in the output registers on the next clock edge, giving a latency of 1 cycle.
REQ-018 On the edge after an accept, out_valid SHALL be 1; on the edge after a transfer with no accept, out_valid SHALL be 0.
REQ-019 While out_valid=1 and out_ready=0, out_idx, out_onehot, out_none and out_multi SHALL hold stable.
REQ-020 A simultaneous transfer and accept SHALL load the new result with no bubble cycle.
REQ-021 In PRIO_FIXED mode, the highest set bit number SHALL win.
REQ-022 In PRIO_RR mode, the search SHALL start at pointer ptr and descend with wrap-around: ptr, ptr-1, ..., 0, N-1, ..., ptr+1.
REQ-023 In PRIO_RR mode, an accept of a nonzero vector granting g SHALL set ptr to (g-1) mod N, so g becomes lowest priority.
REQ-024 An accept of an all-zero vector SHALL set out_none=1, out_idx=0, out_onehot=0 and out_multi=0, and SHALL leave ptr unchanged.
REQ-025 out_multi SHALL be computed on the accepted vector independent of MODE.
REQ-026 In PRIO_FIXED mode, ptr SHALL be constant at N-1, so the two modes are identical until the first RR grant.
REQ-027 ptr SHALL change only on accept; a vector that is offered but not accepted SHALL have no effect.

Reset
REQ-028 When rst_n=0 at a rising edge, out_valid SHALL be 0, out_idx 0, out_onehot 0, out_none 0, out_multi 0 and ptr N-1.
REQ-029 Reset SHALL take priority over a simultaneous accept or transfer; any pending result SHALL be discarded.
REQ-030 in_ready SHALL read 1 in the first cycle after reset release.

Structure
REQ-031 Package prio_enc_pkg SHALL hold the typedef enum prio_mode_e {PRIO_FIXED, PRIO_RR}; no other shared constants are required.
REQ-032 Sub-module prio_find_first (combinational: vector, start pointer -> index, found) SHALL implement the wrap-around search.
REQ-033 prio_encoder_rr SHALL hold all state: the output registers and ptr.

Verification
REQ-034 N=8, PRIO_FIXED, in_req=8'b1000_0001, out_ready=1 -> next cycle out_idx=7, out_onehot=8'h80, out_multi=1, out_none=0.
REQ-035 N=8, in_req=8'h00 accepted -> out_none=1, out_idx=0, out_onehot=0; in PRIO_RR mode ptr stays unchanged.
REQ-036 Backpressure: result valid, out_ready=0 for 3 cycles, in_valid=1 with 8'h01 -> in_ready=0, outputs stable; out_ready=1 -> transfer, 8'h01 accepted, out_idx=0 next cycle.
REQ-037 N=8, PRIO_RR, four accepts of 8'hFF -> out_idx 7,6,5,4; then 8'b1000_0001 -> idx 0 (ptr=3); then 8'b1000_0001 again -> idx 7.
REQ-038 Back-to-back: in_valid=1 and out_ready=1 every cycle with 8'h10,8'h20,8'h40 -> out_idx 4,5,6 on consecutive cycles, out_valid never drops.
REQ-039 Reset mid-operation: out_valid=1, out_ready=0, PRIO_RR ptr=3, rst_n=0 for one edge -> out_valid=0, all outputs 0, ptr=7; next 8'hFF -> idx 7.
